wave_cmd_engine: RTL and testbench
==================================

// Module: wave_cmd_engine
//
// PURPOSE
//   Consumes the 4-bit command strobes produced by the SPI client stage and keeps the waveform
//   generator state: run/stop, wave shape, frequency index and amplitude index.
//   Drives a phase-accumulator sample generator that emits one DATA_W-bit sample every
//   TICK_DIV clocks while running.
//   Sits directly downstream of the SPI receive stage; its sample output feeds the DAC driver.
//
// PARAMETERS
//   TICK_DIV  10     clocks per output sample (>=2)
//   PHASE_W   16     phase accumulator width
//   DATA_W    8      sample width (<= PHASE_W-1)
//   BASE_INC  256    phase increment at freq_idx=0; inc = (BASE_INC << freq_idx) mod 2^PHASE_W
//
// PORTS
//   clk           in   1       system clock (same clock as the SPI receive stage)
//   rst_n         in   1       asynchronous, active-low reset
//   command       in   4       command code, valid only when command_signal=1
//   command_signal in  1       single-cycle command strobe
//   sample        out  DATA_W  current waveform sample
//   sample_valid  out  1       1-cycle pulse when sample updates
//   running       out  1       generator enabled
//   wave_sel      out  2       0=square 1=triangle 2=saw (3 unused)
//   freq_idx      out  3       frequency step 0..7
//   amp_idx       out  2       amplitude step 0..3 (3 = full scale)
//   cmd_err       out  1       1-cycle pulse on an undefined command code
//
// BEHAVIOUR
//   Reset: sample=0, sample_valid=0, running=0, wave_sel=2 (saw), freq_idx=0, amp_idx=3,
//     cmd_err=0, phase=0, tick counter=0.
//   Commands take effect on the clock edge where command_signal=1; outputs reflect them 1 cycle later.
//   Command codes:
//     0x0 NOP
//     0x1 RUN: running<=1; tick counter restarts at 0
//     0x2 STOP: running<=0; tick counter<=0; sample<=0; phase holds
//     0x3/0x4/0x5: wave_sel <= 0/1/2
//     0x6 FREQ_UP / 0x7 FREQ_DOWN: freq_idx +/-1, saturating at 7 / 0, no wrap
//     0x8 AMP_UP / 0x9 AMP_DOWN: amp_idx +/-1, saturating at 3 / 0, no wrap
//     0xA PHASE_RST: phase<=0
//     0xF SOFT_RESET: every register returns to its reset value in one cycle
//     Any other code: no state change; cmd_err pulses for 1 cycle
//   RUN while already running: restarts the tick counter only; phase is untouched.
//   Tick:
//     - the counter counts 0..TICK_DIV-1 only while running
//     - tick is asserted when count==TICK_DIV-1; the counter wraps to 0
//     - on a tick: sample <= scale(shape(phase)), phase <= phase + inc, sample_valid=1 the same
//       edge (registered)
//     - the first sample_valid is TICK_DIV clocks after the RUN strobe edge
//   Shape, with p = phase before increment:
//     - saw = p[PHASE_W-1 -: DATA_W]
//     - square = p[PHASE_W-1] ? all-ones : 0
//     - triangle = p[PHASE_W-1] ? ~t : t, where t = p[PHASE_W-2 -: DATA_W]
//   scale(x) = x >> (3 - amp_idx) (logical shift). Accumulator wraps modulo 2^PHASE_W.
//   Simultaneous events:
//     - command in the same cycle as a tick: the tick uses the old settings
//     - PHASE_RST coinciding with a tick: phase<=0 wins over the increment, but sample still
//       takes shape(old phase)
//     - STOP coinciding with a tick: STOP wins; no sample_valid; sample<=0
//   rst_n asserted mid-operation: all state clears immediately and asynchronously.
//   Strobes arriving back-to-back on consecutive cycles are each processed; no queuing is needed.
//
// STRUCTURE
//   wavegen_pkg: cmd_e enum (codes above), wave_e enum, and reset-default localparams for
//     wave_sel, freq_idx and amp_idx.
//   Sub-module wave_phase_gen contains the tick divider, phase accumulator, shape and scale logic.
//     Inputs: run, clr_tick, phase_rst, wave_sel, freq_idx, amp_idx.
//     Outputs: sample, sample_valid.
//   The top level holds the command decode and the settings registers.
//
// TESTING
//   1. Reset then idle 50 clks -> running=0, wave_sel=2, freq_idx=0, amp_idx=3,
//      sample=0, no sample_valid.
//   2. RUN (saw, f0, amp3) -> sample_valid every 10 clks, first 10 clks after the strobe;
//      sample sequence 0x00,0x01,0x02,...; 0xFF wraps to 0x00.
//   3. Seven FREQ_UP -> freq_idx=7 and one more FREQ_UP keeps 7; AMP_DOWN x4 -> amp_idx=0;
//      saw samples are right-shifted by 3.
//   4. Triangle, f7 (inc=0x8000), amp3, after PHASE_RST -> samples alternate 0x00, 0xFF.
//   5. Code 0xB -> cmd_err pulse of 1 cycle; all settings are unchanged.
//   6. STOP issued on the tick cycle -> no sample_valid and sample=0; then RUN gives first
//      sample 10 clks later, continuing from the held phase. Repeat with rst_n dropped
//      mid-run -> everything clears.

Source files
------------

// File: rtl/wavegen_pkg.sv
// Shared types and reset defaults for the waveform command engine.
package wavegen_pkg;

  typedef enum logic [3:0] {
    CMD_NOP       = 4'h0,
    CMD_RUN       = 4'h1,
    CMD_STOP      = 4'h2,
    CMD_SQUARE    = 4'h3,
    CMD_TRIANGLE  = 4'h4,
    CMD_SAW       = 4'h5,
    CMD_FREQ_UP   = 4'h6,
    CMD_FREQ_DOWN = 4'h7,
    CMD_AMP_UP    = 4'h8,
    CMD_AMP_DOWN  = 4'h9,
    CMD_PHASE_RST = 4'hA,
    CMD_SOFT_RST  = 4'hF
  } cmd_e;

  typedef enum logic [1:0] {
    WAVE_SQUARE   = 2'd0,
    WAVE_TRIANGLE = 2'd1,
    WAVE_SAW      = 2'd2
  } wave_e;

  localparam logic [1:0] WAVE_SEL_RST = WAVE_SAW;
  localparam logic [2:0] FREQ_IDX_RST = 3'd0;
  localparam logic [2:0] FREQ_IDX_MAX = 3'd7;
  localparam logic [1:0] AMP_IDX_RST  = 2'd3;
  localparam logic [1:0] AMP_IDX_MAX  = 2'd3;

endpackage

// File: rtl/wave_phase_gen.sv
// Tick divider, phase accumulator and shape/scale stage of the waveform generator.
module wave_phase_gen
  import wavegen_pkg::*;
#(
  parameter int TICK_DIV = 10,
  parameter int PHASE_W  = 16,
  parameter int DATA_W   = 8,
  parameter int BASE_INC = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run_i,        // qualified run: already low on a STOP/soft-reset cycle
  input  logic              clr_tick_i,   // restart the divider without disturbing a tick
  input  logic              phase_rst_i,  // phase <= 0, wins over the increment
  input  logic [1:0]        wave_sel_i,
  input  logic [2:0]        freq_idx_i,
  input  logic [1:0]        amp_idx_i,
  output logic [DATA_W-1:0] sample_o,
  output logic              sample_valid_o
);

  localparam int CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [PHASE_W-1:0] phase_q, phase_d;
  logic [PHASE_W-1:0] inc;
  logic [DATA_W-1:0]  sample_q, sample_d;
  logic               vld_q, vld_d;
  logic               tick;

  function automatic logic [DATA_W-1:0] shape(input logic [PHASE_W-1:0] p,
                                               input logic [1:0] sel);
    logic [DATA_W-1:0] t;
    t = p[PHASE_W-2 -: DATA_W];
    case (sel)
      WAVE_SQUARE:   shape = p[PHASE_W-1] ? '1 : '0;
      WAVE_TRIANGLE: shape = p[PHASE_W-1] ? ~t : t;
      default:       shape = p[PHASE_W-1 -: DATA_W];
    endcase
  endfunction

  // Amplitude step 3 is full scale; each step down halves the sample.
  function automatic logic [DATA_W-1:0] scale(input logic [DATA_W-1:0] x,
                                               input logic [1:0] amp);
    logic [1:0] sh;
    sh = 2'd3 - amp;
    scale = x >> sh;
  endfunction

  // Increment doubles per frequency step and wraps with the accumulator width.
  assign inc = PHASE_W'(BASE_INC) << freq_idx_i;

  // Next-state: divider, tick-time sample capture and phase advance.
  always_comb begin
    cnt_d    = cnt_q;
    phase_d  = phase_q;
    sample_d = sample_q;
    vld_d    = 1'b0;
    tick     = run_i && (cnt_q == CNT_LAST);
    if (!run_i) begin
      cnt_d    = '0;
      sample_d = '0;
    end else begin
      if (tick) begin
        sample_d = scale(shape(phase_q, wave_sel_i), amp_idx_i);
        vld_d    = 1'b1;
        phase_d  = phase_q + inc;
      end
      if (tick || clr_tick_i) cnt_d = '0;
      else                    cnt_d = cnt_q + 1'b1;
    end
    if (phase_rst_i) phase_d = '0;
  end

  // Generator state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      phase_q  <= '0;
      sample_q <= '0;
      vld_q    <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      phase_q  <= phase_d;
      sample_q <= sample_d;
      vld_q    <= vld_d;
    end
  end

  assign sample_o       = sample_q;
  assign sample_valid_o = vld_q;

endmodule

// File: rtl/wave_cmd_engine.sv
// Command decode and settings registers for the waveform generator; drives wave_phase_gen.
module wave_cmd_engine
  import wavegen_pkg::*;
#(
  parameter int TICK_DIV = 10,
  parameter int PHASE_W  = 16,
  parameter int DATA_W   = 8,
  parameter int BASE_INC = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        command,
  input  logic              command_signal,
  output logic [DATA_W-1:0] sample,
  output logic              sample_valid,
  output logic              running,
  output logic [1:0]        wave_sel,
  output logic [2:0]        freq_idx,
  output logic [1:0]        amp_idx,
  output logic              cmd_err
);

  logic       running_q, running_d;
  logic [1:0] wave_q, wave_d;
  logic [2:0] freq_q, freq_d;
  logic [1:0] amp_q, amp_d;
  logic       err_q, err_d;
  logic       stop_now;   // STOP or soft reset this cycle: suppresses a coinciding tick
  logic       clr_tick;
  logic       phase_rst;
  logic       gen_run;

  // Decode the strobed command into next settings and generator controls.
  always_comb begin
    running_d = running_q;
    wave_d    = wave_q;
    freq_d    = freq_q;
    amp_d     = amp_q;
    err_d     = 1'b0;
    stop_now  = 1'b0;
    clr_tick  = 1'b0;
    phase_rst = 1'b0;
    if (command_signal) begin
      case (cmd_e'(command))
        CMD_NOP: ;
        CMD_RUN: begin
          running_d = 1'b1;
          clr_tick  = 1'b1;
        end
        CMD_STOP: begin
          running_d = 1'b0;
          stop_now  = 1'b1;
        end
        CMD_SQUARE:    wave_d = WAVE_SQUARE;
        CMD_TRIANGLE:  wave_d = WAVE_TRIANGLE;
        CMD_SAW:       wave_d = WAVE_SAW;
        CMD_FREQ_UP:   if (freq_q != FREQ_IDX_MAX) freq_d = freq_q + 3'd1;
        CMD_FREQ_DOWN: if (freq_q != 3'd0)         freq_d = freq_q - 3'd1;
        CMD_AMP_UP:    if (amp_q != AMP_IDX_MAX)   amp_d  = amp_q + 2'd1;
        CMD_AMP_DOWN:  if (amp_q != 2'd0)          amp_d  = amp_q - 2'd1;
        CMD_PHASE_RST: phase_rst = 1'b1;
        CMD_SOFT_RST: begin
          running_d = 1'b0;
          wave_d    = WAVE_SEL_RST;
          freq_d    = FREQ_IDX_RST;
          amp_d     = AMP_IDX_RST;
          stop_now  = 1'b1;
          phase_rst = 1'b1;
        end
        default: err_d = 1'b1;
      endcase
    end
  end

  // A tick in the same cycle as a command still sees the old settings; only STOP kills it.
  assign gen_run = running_q && !stop_now;

  // Settings and error-pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      running_q <= 1'b0;
      wave_q    <= WAVE_SEL_RST;
      freq_q    <= FREQ_IDX_RST;
      amp_q     <= AMP_IDX_RST;
      err_q     <= 1'b0;
    end else begin
      running_q <= running_d;
      wave_q    <= wave_d;
      freq_q    <= freq_d;
      amp_q     <= amp_d;
      err_q     <= err_d;
    end
  end

  wave_phase_gen #(
    .TICK_DIV (TICK_DIV),
    .PHASE_W  (PHASE_W),
    .DATA_W   (DATA_W),
    .BASE_INC (BASE_INC)
  ) u_gen (
    .clk            (clk),
    .rst_n          (rst_n),
    .run_i          (gen_run),
    .clr_tick_i     (clr_tick),
    .phase_rst_i    (phase_rst),
    .wave_sel_i     (wave_q),
    .freq_idx_i     (freq_q),
    .amp_idx_i      (amp_q),
    .sample_o       (sample),
    .sample_valid_o (sample_valid)
  );

  assign running  = running_q;
  assign wave_sel = wave_q;
  assign freq_idx = freq_q;
  assign amp_idx  = amp_q;
  assign cmd_err  = err_q;

endmodule

// File: tb/tb_wave_cmd_engine.sv
// Scoreboard bench for wave_cmd_engine: a behavioural reference pushes expected samples,
// the monitor pops them whenever the DUT raises sample_valid.
module tb_wave_cmd_engine;

  localparam int TICK_DIV = 10;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] command = 4'h0;
  logic       command_signal = 1'b0;
  logic [7:0] sample;
  logic       sample_valid;
  logic       running;
  logic [1:0] wave_sel;
  logic [2:0] freq_idx;
  logic [1:0] amp_idx;
  logic       cmd_err;

  int n_checks = 0;
  int n_errors = 0;
  int vld_total = 0;
  logic [7:0] exp_q[$];
  logic [7:0] seen[$];

  always #5 clk = ~clk;

  wave_cmd_engine #(
    .TICK_DIV (TICK_DIV),
    .PHASE_W  (16),
    .DATA_W   (8),
    .BASE_INC (256)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .command        (command),
    .command_signal (command_signal),
    .sample         (sample),
    .sample_valid   (sample_valid),
    .running        (running),
    .wave_sel       (wave_sel),
    .freq_idx       (freq_idx),
    .amp_idx        (amp_idx),
    .cmd_err        (cmd_err)
  );

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Reference sample from the phase, written arithmetically.
  function automatic logic [7:0] ref_sample(input logic [15:0] p, input logic [1:0] w,
                                            input logic [1:0] a);
    int v;
    int hi;
    hi = (p >= 16'h8000) ? 1 : 0;
    case (w)
      2'd0: v = hi ? 255 : 0;
      2'd1: begin
        v = (int'(p) % 32768) / 128;
        if (hi != 0) v = 255 - v;
      end
      default: v = int'(p) / 256;
    endcase
    return 8'(v / (1 << (3 - int'(a))));
  endfunction

  logic        m_run;
  logic [1:0]  m_wave, m_amp;
  logic [2:0]  m_freq;
  logic [15:0] m_phase;
  int          m_cnt;
  logic        m_tick, m_stop, m_soft, m_runc, m_prst;

  assign m_tick = m_run && (m_cnt == TICK_DIV - 1);
  assign m_stop = command_signal && (command == 4'h2);
  assign m_soft = command_signal && (command == 4'hF);
  assign m_runc = command_signal && (command == 4'h1);
  assign m_prst = command_signal && (command == 4'hA);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n || m_soft) begin
      m_run <= 1'b0; m_wave <= 2'd2; m_freq <= 3'd0; m_amp <= 2'd3;
      m_phase <= 16'h0; m_cnt <= 0;
    end else begin
      if (m_tick && !m_stop) exp_q.push_back(ref_sample(m_phase, m_wave, m_amp));
      if (m_prst) m_phase <= 16'h0;
      else if (m_tick && !m_stop) m_phase <= m_phase + 16'((256 * (1 << m_freq)) % 65536);
      if (!m_run || m_stop || m_runc || m_tick) m_cnt <= 0;
      else m_cnt <= m_cnt + 1;
      if (m_runc) m_run <= 1'b1;
      else if (m_stop) m_run <= 1'b0;
      if (command_signal) begin
        case (command)
          4'h3: m_wave <= 2'd0;
          4'h4: m_wave <= 2'd1;
          4'h5: m_wave <= 2'd2;
          4'h6: if (m_freq < 3'd7) m_freq <= m_freq + 3'd1;
          4'h7: if (m_freq > 3'd0) m_freq <= m_freq - 3'd1;
          4'h8: if (m_amp < 2'd3) m_amp <= m_amp + 2'd1;
          4'h9: if (m_amp > 2'd0) m_amp <= m_amp - 2'd1;
          default: ;
        endcase
      end
    end
  end

  // Monitor: pop one expectation per DUT sample_valid; a leftover means a missed tick.
  always @(negedge clk) begin
    if (rst_n) begin
      if (sample_valid) begin
        vld_total <= vld_total + 1;
        seen.push_back(sample);
        if (exp_q.size() == 0) check_val("unexpected_valid", 32'(sample_valid), 0);
        else check_val("sample", 32'(sample), 32'(exp_q.pop_front()));
      end else if (exp_q.size() != 0) begin
        check_val("missing_valid", 32'(sample_valid), 1);
        void'(exp_q.pop_front());
      end
    end
  end

  task automatic send_cmd(input logic [3:0] c);
    command = c;
    command_signal = 1'b1;
    @(negedge clk);
    command_signal = 1'b0;
    command = 4'h0;
  endtask

  task automatic measure_latency(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!sample_valid && n < 40);
  endtask

  task automatic sync_valid(input string tag);
    int g;
    g = 0;
    do begin
      @(negedge clk);
      g++;
    end while (!sample_valid && g < 40);
    if (!sample_valid) check_val(tag, 32'(sample_valid), 1);
    #1 seen.delete();
  endtask

  task automatic wait_samples(input int k, input string tag);
    int g;
    g = 0;
    while (seen.size() < k && g < k * TICK_DIV + 40) begin
      @(negedge clk);
      g++;
    end
    #1;
    if (seen.size() < k) check_val(tag, 32'(seen.size()), 32'(k));
  endtask

  task automatic check_defaults(input string tag);
    check_val({tag, "_running"}, 32'(running), 0);
    check_val({tag, "_wave"}, 32'(wave_sel), 2);
    check_val({tag, "_freq"}, 32'(freq_idx), 0);
    check_val({tag, "_amp"}, 32'(amp_idx), 3);
    check_val({tag, "_sample"}, 32'(sample), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat;
    int vsnap;

    // Reset and idle.
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (50) @(negedge clk);
    check_defaults("reset");
    check_val("reset_cmd_err", 32'(cmd_err), 0);
    check_val("idle_no_valid", 32'(vld_total), 0);

    // RUN with saw/f0/amp3: latency, spacing and ramp with wrap.
    send_cmd(4'h1);
    check_val("run_running", 32'(running), 1);
    measure_latency(lat);
    check_val("first_latency", 32'(lat), 10);
    measure_latency(lat);
    check_val("tick_spacing", 32'(lat), 10);
    wait_samples(257, "ramp_timeout");
    check_val("ramp0", 32'(seen[0]), 32'h00);
    check_val("ramp1", 32'(seen[1]), 32'h01);
    check_val("ramp2", 32'(seen[2]), 32'h02);
    check_val("ramp255", 32'(seen[255]), 32'hFF);
    check_val("ramp_wrap", 32'(seen[256]), 32'h00);

    // Frequency/amplitude saturation, back-to-back strobes.
    repeat (7) send_cmd(4'h6);
    check_val("freq_max", 32'(freq_idx), 7);
    send_cmd(4'h6);
    check_val("freq_sat", 32'(freq_idx), 7);
    repeat (4) send_cmd(4'h9);
    check_val("amp_min", 32'(amp_idx), 0);
    sync_valid("amp0_sync");
    wait_samples(2, "amp0_timeout");
    check_val("amp0_range0", 32'(seen[0] >> 5), 0);
    check_val("amp0_range1", 32'(seen[1] >> 5), 0);

    // Triangle at f7 after PHASE_RST alternates 00/FF.
    repeat (3) send_cmd(4'h8);
    check_val("amp_max", 32'(amp_idx), 3);
    send_cmd(4'h4);
    check_val("wave_tri", 32'(wave_sel), 1);
    sync_valid("tri_sync");
    send_cmd(4'hA);
    wait_samples(4, "tri_timeout");
    check_val("tri0", 32'(seen[0]), 32'h00);
    check_val("tri1", 32'(seen[1]), 32'hFF);
    check_val("tri2", 32'(seen[2]), 32'h00);
    check_val("tri3", 32'(seen[3]), 32'hFF);

    // Undefined code.
    send_cmd(4'hB);
    check_val("err_pulse", 32'(cmd_err), 1);
    check_val("err_wave", 32'(wave_sel), 1);
    check_val("err_freq", 32'(freq_idx), 7);
    check_val("err_amp", 32'(amp_idx), 3);
    check_val("err_running", 32'(running), 1);
    @(negedge clk);
    check_val("err_one_cycle", 32'(cmd_err), 0);

    // STOP landing exactly on a tick edge.
    sync_valid("stop_sync");
    repeat (9) @(negedge clk);
    send_cmd(4'h2);
    check_val("stop_no_valid", 32'(sample_valid), 0);
    check_val("stop_sample", 32'(sample), 0);
    check_val("stop_running", 32'(running), 0);
    vsnap = vld_total;
    repeat (30) @(negedge clk);
    check_val("stopped_quiet", 32'(vld_total), 32'(vsnap));
    send_cmd(4'h5);
    repeat (8) send_cmd(4'h7);
    check_val("freq_floor", 32'(freq_idx), 0);
    send_cmd(4'h1);
    measure_latency(lat);
    check_val("restart_latency", 32'(lat), 10);
    wait_samples(1, "restart_timeout");

    // Soft reset while running.
    send_cmd(4'hF);
    check_defaults("soft");
    send_cmd(4'h1);
    measure_latency(lat);
    check_val("soft_latency", 32'(lat), 10);
    check_val("soft_first", 32'(sample), 0);

    // Asynchronous reset mid-run.
    send_cmd(4'h4);
    repeat (3) send_cmd(4'h6);
    sync_valid("rst_sync");
    wait_samples(2, "rst_timeout");
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_defaults("async_rst");
    check_val("async_rst_err", 32'(cmd_err), 0);
    @(negedge clk);
    rst_n = 1'b1;
    vsnap = vld_total;
    repeat (30) @(negedge clk);
    check_val("post_rst_quiet", 32'(vld_total), 32'(vsnap));
    check_val("post_rst_running", 32'(running), 0);

    check_val("scoreboard_empty", 32'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
